// File: rtl/wb_xbar_pkg.sv
// Shared types and helpers for the Wishbone 1-to-N address decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   xbar_state_t  - decoder FSM states
//   DEF_ERR_DATA  - read data returned on error terminations unless overridden
//   clog2()       - bit width needed to hold values 0..value-1, never below 1
package wb_xbar_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } xbar_state_t;

    localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

    // A width of at least 1 keeps single-slave and tiny-timeout builds legal.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/wb_addr_match.sv
// Address decoder: maps an address onto the slave table, lowest slot wins on overlap.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no state and no handshake.
//
// Ports:
//   adr  in   32     address to decode
//   hit  out  1      address falls inside at least one slave window
//   idx  out  IDX_W  winning slot index, 0 when there is no hit
module wb_addr_match
    import wb_xbar_pkg::*;
#(
    parameter int                   N_SLV    = 2,
    parameter int                   IDX_W    = 1,
    parameter logic [N_SLV*32-1:0]  SLV_BASE = '0,
    parameter logic [N_SLV*32-1:0]  SLV_MASK = '0
) (
    input  logic [31:0]      adr,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    // Walk from the highest slot down so the last match written is the
    // lowest index, which gives the priority encoding for overlapping windows.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int k = N_SLV - 1; k >= 0; k--) begin
            if ((adr & SLV_MASK[k*32 +: 32]) == (SLV_BASE[k*32 +: 32] & SLV_MASK[k*32 +: 32])) begin
                hit = 1'b1;
                idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/wb_xbar_decoder.sv
// Wishbone classic 1-master to N_SLV-slave decoder with timeout and error termination.
// Latency: strobe to slave 1 cycle after request; master ack same cycle as slave ack; miss errors in cycle 1.
// Backpressure: slave wait states stall the master up to TIMEOUT cycles, then an error ack ends the cycle.
//
// Ports:
//   wbs_clk_i, wbs_rst_ni                 clock, asynchronous active-low reset
//   wbs_stb_i/cyc_i/we_i/sel_i/dat_i/adr_i master request
//   wbs_ack_o/err_o/dat_o                 master response (err qualifies ack)
//   s_stb_o/s_cyc_o                       per-slave strobe, one-hot or zero, only in BUSY
//   s_we_o/s_sel_o/s_dat_o/s_adr_o        request fields broadcast combinationally
//   s_ack_i/s_dat_i                       per-slave responses, s_dat_i packed 32 bits per slot
//   err_cnt_o                             saturating count of error terminations
module wb_xbar_decoder
    import wb_xbar_pkg::*;
#(
    parameter int                   N_SLV    = 2,
    parameter logic [N_SLV*32-1:0]  SLV_BASE = {32'h3800_0000, 32'h3000_0000},
    parameter logic [N_SLV*32-1:0]  SLV_MASK = {32'hFF00_0000, 32'hFF00_0000},
    parameter int                   TIMEOUT  = 255,
    parameter logic [31:0]          ERR_DATA = DEF_ERR_DATA
) (
    input  logic                wbs_clk_i,
    input  logic                wbs_rst_ni,
    input  logic                wbs_stb_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_dat_i,
    input  logic [31:0]         wbs_adr_i,
    output logic                wbs_ack_o,
    output logic                wbs_err_o,
    output logic [31:0]         wbs_dat_o,
    output logic [N_SLV-1:0]    s_stb_o,
    output logic [N_SLV-1:0]    s_cyc_o,
    output logic                s_we_o,
    output logic [3:0]          s_sel_o,
    output logic [31:0]         s_dat_o,
    output logic [31:0]         s_adr_o,
    input  logic [N_SLV-1:0]    s_ack_i,
    input  logic [N_SLV*32-1:0] s_dat_i,
    output logic [15:0]         err_cnt_o
);

    localparam int                GNT_W    = clog2(N_SLV);
    localparam int                TMO_W    = clog2(TIMEOUT);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

    xbar_state_t        state_q, state_d;
    logic [GNT_W-1:0]   grant_q, grant_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [15:0]        err_cnt_q;

    logic               req;
    logic               dec_hit;
    logic [GNT_W-1:0]   dec_idx;
    logic               gnt_ack;
    logic [31:0]        gnt_dat;

    assign req = wbs_stb_i & wbs_cyc_i;

    wb_addr_match #(
        .N_SLV    (N_SLV),
        .IDX_W    (GNT_W),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_match (
        .adr (wbs_adr_i),
        .hit (dec_hit),
        .idx (dec_idx)
    );

    // Request fields are never registered; slaves see them as the master drives them.
    assign s_we_o  = wbs_we_i;
    assign s_sel_o = wbs_sel_i;
    assign s_dat_o = wbs_dat_i;
    assign s_adr_o = wbs_adr_i;

    // Select the granted slave's response. Only the granted slot is ever
    // looked at, so stray acks from other slaves cannot complete a cycle.
    always_comb begin
        gnt_ack = 1'b0;
        gnt_dat = '0;
        for (int k = 0; k < N_SLV; k++) begin
            if (grant_q == GNT_W'(k)) begin
                gnt_ack = s_ack_i[k];
                gnt_dat = s_dat_i[k*32 +: 32];
            end
        end
    end

    // Strobe follows the master combinationally while BUSY, so dropping stb
    // or cyc withdraws it in the same cycle.
    always_comb begin
        s_stb_o = '0;
        for (int k = 0; k < N_SLV; k++) begin
            s_stb_o[k] = (state_q == BUSY) && req && (grant_q == GNT_W'(k));
        end
    end

    assign s_cyc_o = s_stb_o;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        tmo_d     = tmo_q;
        wbs_ack_o = 1'b0;
        wbs_err_o = 1'b0;
        wbs_dat_o = '0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (dec_hit) begin
                        grant_d = dec_idx;
                        tmo_d   = '0;
                        state_d = BUSY;
                    end else begin
                        state_d = ERR;
                    end
                end
            end

            BUSY: begin
                // Abort has priority: a master that gave up the bus gets no ack.
                if (!wbs_cyc_i) begin
                    state_d = IDLE;
                end else if (gnt_ack) begin
                    wbs_ack_o = 1'b1;
                    wbs_dat_o = gnt_dat;
                    state_d   = IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ERR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            ERR: begin
                wbs_ack_o = 1'b1;
                wbs_err_o = 1'b1;
                wbs_dat_o = ERR_DATA;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wbs_clk_i or negedge wbs_rst_ni) begin
        if (!wbs_rst_ni) begin
            state_q <= IDLE;
            grant_q <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            tmo_q   <= tmo_d;
        end
    end

    // One increment per error termination; ERR lasts exactly one cycle.
    always_ff @(posedge wbs_clk_i or negedge wbs_rst_ni) begin
        if (!wbs_rst_ni) begin
            err_cnt_q <= '0;
        end else if ((state_q == ERR) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_wb_xbar_decoder.sv
// Scoreboard bench for wb_xbar_decoder: directed cases then randomized traffic.
// Three slaves with an overlapping third window exercise the priority decode.
module tb_wb_xbar_decoder;

    localparam int N   = 3;
    localparam int TMO = 8;
    // slot0 0x30xxxxxx, slot1 0x38xxxxxx, slot2 0x3xxxxxxx (overlaps both, lowest slot wins)
    localparam logic [N*32-1:0] TB_BASE = {32'h3000_0000, 32'h3800_0000, 32'h3000_0000};
    localparam logic [N*32-1:0] TB_MASK = {32'hF000_0000, 32'hFF00_0000, 32'hFF00_0000};
    localparam logic [31:0]     TB_ERR  = 32'hDEAD_BEEF;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wbs_stb_i = 1'b0;
    logic            wbs_cyc_i = 1'b0;
    logic            wbs_we_i = 1'b0;
    logic [3:0]      wbs_sel_i = '0;
    logic [31:0]     wbs_dat_i = '0;
    logic [31:0]     wbs_adr_i = '0;
    logic            wbs_ack_o;
    logic            wbs_err_o;
    logic [31:0]     wbs_dat_o;
    logic [N-1:0]    s_stb_o;
    logic [N-1:0]    s_cyc_o;
    logic            s_we_o;
    logic [3:0]      s_sel_o;
    logic [31:0]     s_dat_o;
    logic [31:0]     s_adr_o;
    logic [N-1:0]    s_ack_i = '0;
    logic [N*32-1:0] s_dat_i = '0;
    logic [15:0]     err_cnt_o;

    wb_xbar_decoder #(
        .N_SLV    (N),
        .SLV_BASE (TB_BASE),
        .SLV_MASK (TB_MASK),
        .TIMEOUT  (TMO),
        .ERR_DATA (TB_ERR)
    ) dut (
        .wbs_clk_i  (clk),
        .wbs_rst_ni (rst_n),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_err_o  (wbs_err_o),
        .wbs_dat_o  (wbs_dat_o),
        .s_stb_o    (s_stb_o),
        .s_cyc_o    (s_cyc_o),
        .s_we_o     (s_we_o),
        .s_sel_o    (s_sel_o),
        .s_dat_o    (s_dat_o),
        .s_adr_o    (s_adr_o),
        .s_ack_i    (s_ack_i),
        .s_dat_i    (s_dat_i),
        .err_cnt_o  (err_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          err;
        logic [31:0] dat;
        int          lat;
        int          t0;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc_num = 0;
    int          cur_idx = -1;
    int          exp_err_cnt = 0;
    int          cfg_wait[N];
    bit          cfg_spur[N];
    logic [31:0] cfg_dat[N];
    int          wcnt[N];

    always @(posedge clk) cyc_num <= cyc_num + 1;

    task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] req);
        n_chk = n_chk + 1;
        if (ok) n_pass = n_pass + 1;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc_num);
    endtask

    // Reference decode: first slot whose masked base equals the masked address.
    function automatic int exp_slave(input logic [31:0] adr);
        logic [N*32-1:0] b;
        logic [N*32-1:0] m;
        b = TB_BASE;
        m = TB_MASK;
        for (int k = 0; k < N; k++) begin
            if ((adr & m[k*32 +: 32]) == (b[k*32 +: 32] & m[k*32 +: 32])) return k;
        end
        return -1;
    endfunction

    // Slave models: ack after cfg_wait strobed cycles; optional spurious ack while unstrobed.
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (s_stb_o[k]) begin
                if (wcnt[k] >= cfg_wait[k]) begin
                    s_ack_i[k] = 1'b1;
                end else begin
                    s_ack_i[k] = 1'b0;
                    wcnt[k] = wcnt[k] + 1;
                end
            end else begin
                s_ack_i[k] = cfg_spur[k];
                wcnt[k] = 0;
            end
            s_dat_i[k*32 +: 32] = cfg_dat[k];
        end
    end

    // Monitor: compares every master-side ack against the scoreboard.
    always @(negedge clk) begin
        logic [N-1:0] oh;
        exp_t         e;
        #1;
        if (!rst_n) begin
            exp_err_cnt = 0;
            check("reset_out", (wbs_ack_o == 1'b0) && (wbs_err_o == 1'b0) && (wbs_dat_o == 32'h0)
                  && (s_stb_o == '0) && (s_cyc_o == '0) && (err_cnt_o == 16'h0),
                  {wbs_ack_o, wbs_err_o, 14'(s_stb_o), err_cnt_o}, 32'h0);
        end else begin
            oh = '0;
            if (cur_idx >= 0) oh[cur_idx] = 1'b1;
            check("stb_route", (s_cyc_o == s_stb_o) && ((s_stb_o == '0) || (s_stb_o == oh)),
                  32'(s_stb_o), 32'(oh));
            check("pass_thru", (s_adr_o == wbs_adr_i) && (s_dat_o == wbs_dat_i)
                  && (s_sel_o == wbs_sel_i) && (s_we_o == wbs_we_i), s_adr_o, wbs_adr_i);
            if (!wbs_ack_o) begin
                check("quiet_out", (wbs_err_o == 1'b0) && (wbs_dat_o == 32'h0), wbs_dat_o, 32'h0);
            end else if (exp_q.size() == 0) begin
                check("unexpected_ack", 1'b0, 32'(wbs_ack_o), 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("ack_err", wbs_err_o == e.err, 32'(wbs_err_o), 32'(e.err));
                check("ack_dat", wbs_dat_o == e.dat, wbs_dat_o, e.dat);
                check("ack_lat", (cyc_num - e.t0) == e.lat, 32'(cyc_num - e.t0), 32'(e.lat));
                check("err_cnt", err_cnt_o == 16'(exp_err_cnt), 32'(err_cnt_o), 32'(exp_err_cnt));
                if (e.err) begin
                    check("err_no_stb", s_stb_o == '0, 32'(s_stb_o), 32'h0);
                    exp_err_cnt = exp_err_cnt + 1;
                end
            end
        end
    end

    // Issues one transaction aligned just after a rising edge and waits for its ack.
    task automatic run_txn(input logic [31:0] adr, input logic we);
        exp_t e;
        int   idx;
        int   n;
        idx = exp_slave(adr);
        e.t0 = cyc_num;
        if (idx < 0) begin
            e.err = 1'b1; e.dat = TB_ERR; e.lat = 1;
        end else if (cfg_wait[idx] >= TMO) begin
            e.err = 1'b1; e.dat = TB_ERR; e.lat = TMO + 1;
        end else begin
            e.err = 1'b0; e.dat = cfg_dat[idx]; e.lat = cfg_wait[idx] + 1;
        end
        exp_q.push_back(e);
        cur_idx   = idx;
        wbs_adr_i = adr;
        wbs_we_i  = we;
        wbs_sel_i = 4'($urandom);
        wbs_dat_i = $urandom;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        n = 0;
        while (n < 4 * TMO + 20) begin
            @(negedge clk); #2;
            if (wbs_ack_o) break;
            n = n + 1;
        end
        check("ack_seen", n < 4 * TMO + 20, 32'(n), 32'(4 * TMO + 20));
        @(posedge clk); #1;
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        cur_idx   = -1;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic set_slaves(input int w0, input int w1, input int w2);
        cfg_wait[0] = w0; cfg_wait[1] = w1; cfg_wait[2] = w2;
        for (int k = 0; k < N; k++) begin
            cfg_spur[k] = 1'b0;
            cfg_dat[k]  = $urandom;
        end
    endtask

    initial begin
        logic [7:0]  pfx;
        logic [31:0] adr;
        set_slaves(0, 0, 0);
        for (int k = 0; k < N; k++) wcnt[k] = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // write to slot0, zero-wait slave
        set_slaves(0, 0, 0);
        run_txn(32'h3000_0010, 1'b1);
        // read slot1 with 3 wait states
        set_slaves(0, 3, 0);
        cfg_dat[1] = 32'h1234_5678;
        run_txn(32'h3800_0004, 1'b0);
        // unmapped
        run_txn(32'h2000_0000, 1'b0);
        // hung slave0, and the boundary on either side of the timeout
        set_slaves(1000, 0, 0);
        run_txn(32'h3000_0000, 1'b0);
        set_slaves(TMO - 1, 0, 0);
        run_txn(32'h3000_0040, 1'b0);
        set_slaves(TMO, 0, 0);
        run_txn(32'h3000_0080, 1'b1);
        // spurious ack from slave1 while slave0 is granted
        set_slaves(3, 0, 0);
        cfg_spur[1] = 1'b1;
        run_txn(32'h3000_0100, 1'b0);
        // overlap priority: slot2 only where slots 0/1 miss
        set_slaves(1, 2, 0);
        run_txn(32'h3100_0000, 1'b0);
        run_txn(32'h3800_0000, 1'b0);
        run_txn(32'h3000_0000, 1'b1);

        // master drops cyc mid-BUSY: no ack expected
        set_slaves(0, 1000, 0);
        cur_idx = 1;
        wbs_adr_i = 32'h3800_0020; wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; cur_idx = -1;
        repeat (3) begin @(posedge clk); #1; end
        set_slaves(0, 2, 0);
        run_txn(32'h3800_0024, 1'b0);

        // async reset mid-BUSY
        set_slaves(1000, 0, 0);
        cur_idx = 0;
        wbs_adr_i = 32'h3000_0200; wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst", (wbs_ack_o == 1'b0) && (s_stb_o == '0) && (err_cnt_o == 16'h0)
              && (wbs_dat_o == 32'h0), {16'(s_stb_o), err_cnt_o}, 32'h0);
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; cur_idx = -1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        set_slaves(0, 0, 0);
        run_txn(32'h3000_0300, 1'b0);
        run_txn(32'h0000_0000, 1'b0);

        // randomized traffic
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 6))
                0:       pfx = 8'h30;
                1:       pfx = 8'h38;
                2:       pfx = 8'h31;
                3:       pfx = 8'h3F;
                4:       pfx = 8'h20;
                5:       pfx = 8'h00;
                default: pfx = 8'($urandom);
            endcase
            adr = {pfx, 24'($urandom)};
            for (int k = 0; k < N; k++) begin
                cfg_wait[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TMO + 2))
                                                          : int'($urandom_range(0, 2));
                cfg_spur[k] = ($urandom_range(0, 7) == 0);
                cfg_dat[k]  = $urandom;
            end
            run_txn(adr, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size() == 0, 32'(exp_q.size()), 32'h0);
        check("final_err_cnt", err_cnt_o == 16'(exp_err_cnt), 32'(err_cnt_o), 32'(exp_err_cnt));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
